// File: rtl/multimode_counter_n.sv
// multimode_counter_n
//   WIDTH-bit counter with four run-time modes (binary up/down, Gray up/down),
//   synchronous parallel load, terminal-count flag, wrap pulse and optional
//   saturation. All state updates happen on the falling edge of clock.
//
// Ports
//   clock       in   1      clock, state updates on falling edge
//   nreset      in   1      asynchronous active-low reset
//   enable      in   1      advance one step per falling edge
//   mode        in   2      00 bin up, 01 bin down, 10 Gray up, 11 Gray down
//   load        in   1      load load_value on next falling edge (beats enable)
//   load_value  in   WIDTH  binary index to load
//   count       out  WIDTH  registered, encoded per mode
//   tc          out  1      terminal count, combinational from idx and mode
//   wrap        out  1      registered one-cycle pulse after a wrap
module multimode_counter_n #(
  parameter int unsigned WIDTH = 4,
  parameter bit          WRAP  = 1'b1
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] IDX_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] IDX_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] IDX_ONE  = WIDTH'(1);

  // Binary index to output code: identity for binary modes, reflected Gray otherwise.
  function automatic logic [WIDTH-1:0] enc(input logic [WIDTH-1:0] idx,
                                           input logic             gray);
    enc = gray ? (idx ^ (idx >> 1)) : idx;
  endfunction

  logic [WIDTH-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             mode_down;
  logic             mode_gray;
  logic             at_max;
  logic             at_zero;

  assign mode_down = mode[0];
  assign mode_gray = mode[1];
  assign at_max    = (idx_q == IDX_MAX);
  assign at_zero   = (idx_q == IDX_ZERO);

  // Next index and wrap flag: load > enable > hold.
  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (load) begin
      idx_d = load_value;
    end else if (enable) begin
      if (mode_down) begin
        if (at_zero) begin
          if (WRAP) begin
            idx_d  = IDX_MAX;
            wrap_d = 1'b1;
          end
        end else begin
          idx_d = idx_q - IDX_ONE;
        end
      end else begin
        if (at_max) begin
          if (WRAP) begin
            idx_d  = IDX_ZERO;
            wrap_d = 1'b1;
          end
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
    end
  end

  // count is re-encoded every edge so a mode change alone still updates the code.
  always_comb begin
    count_d = enc(idx_d, mode_gray);
  end

  // State registers on the falling edge, cleared asynchronously.
  always_ff @(negedge clock or negedge nreset) begin
    if (!nreset) begin
      idx_q   <= IDX_ZERO;
      count_q <= IDX_ZERO;
      wrap_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign tc    = mode_down ? at_zero : at_max;

endmodule

// File: tb/tb_multimode_counter_n.sv
// Directed testbench for multimode_counter_n (WIDTH=4), one wrapping and one
// saturating instance sharing stimulus.
module tb_multimode_counter_n;

  logic       clock;
  logic       nreset;
  logic       enable;
  logic [1:0] mode;
  logic       load;
  logic [3:0] load_value;
  logic [3:0] count_w, count_s;
  logic       tc_w, tc_s, wrap_w, wrap_s;

  int total = 0;
  int bad   = 0;

  logic [3:0] gray_tbl [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                                4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

  multimode_counter_n #(.WIDTH(4), .WRAP(1'b1)) u_w (
    .clock(clock), .nreset(nreset), .enable(enable), .mode(mode), .load(load),
    .load_value(load_value), .count(count_w), .tc(tc_w), .wrap(wrap_w)
  );

  multimode_counter_n #(.WIDTH(4), .WRAP(1'b0)) u_s (
    .clock(clock), .nreset(nreset), .enable(enable), .mode(mode), .load(load),
    .load_value(load_value), .count(count_s), .tc(tc_s), .wrap(wrap_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance past one active (falling) edge; sample/drive 1ns later.
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0; load = 1'b0;
    nreset = 1'b0;
    #2;
    nreset = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (count_w !== 4'h0 || wrap_w !== 1'b0 || tc_w !== 1'b0) begin
      bad++;
      $display("FAIL reset: count=%h wrap=%b tc=%b want 0/0/0", count_w, wrap_w, tc_w);
    end
    tick();
    nreset = 1'b1;
  endtask

  task automatic test_async_reset();
    mode = 2'b00; enable = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    total++;
    if (count_w !== 4'h7) begin
      bad++;
      $display("FAIL async_pre: count=%h want 7", count_w);
    end
    #1;
    nreset = 1'b0;
    #1;
    total++;
    if (count_w !== 4'h0 || wrap_w !== 1'b0) begin
      bad++;
      $display("FAIL async_clear: count=%h wrap=%b want 0/0", count_w, wrap_w);
    end
    nreset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++;
      if (count_w !== 4'(i)) begin
        bad++;
        $display("FAIL async_restart[%0d]: count=%h want %h", i, count_w, 4'(i));
      end
    end
  endtask

  task automatic test_bin_up();
    logic [3:0] exp;
    do_reset();
    mode = 2'b00; enable = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      exp = 4'(i);
      total++;
      if (count_w !== exp || wrap_w !== (i == 16) || tc_w !== (exp == 4'hF)) begin
        bad++;
        $display("FAIL bin_up[%0d]: count=%h wrap=%b tc=%b want %h/%b/%b",
                 i, count_w, wrap_w, tc_w, exp, (i == 16), (exp == 4'hF));
      end
    end
  endtask

  task automatic test_gray_up();
    logic [3:0] prev;
    do_reset();
    mode = 2'b10; enable = 1'b1;
    prev = 4'h0;
    for (int i = 0; i < 16; i++) begin
      tick();
      total++;
      if (count_w !== gray_tbl[i] || wrap_w !== (i == 15) ||
          tc_w !== (gray_tbl[i] == 4'h8) || $countones(count_w ^ prev) != 1) begin
        bad++;
        $display("FAIL gray_up[%0d]: count=%h wrap=%b tc=%b want %h/%b/%b",
                 i, count_w, wrap_w, tc_w, gray_tbl[i], (i == 15), (gray_tbl[i] == 4'h8));
      end
      prev = count_w;
    end
  endtask

  task automatic test_load_down();
    logic [3:0] exp_cnt [5] = '{4'h3, 4'h2, 4'h1, 4'h0, 4'hF};
    do_reset();
    mode = 2'b01; load = 1'b1; load_value = 4'h3; enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      load = 1'b0; enable = 1'b1;
      total++;
      if (count_w !== exp_cnt[i] || tc_w !== (exp_cnt[i] == 4'h0) || wrap_w !== (i == 4)) begin
        bad++;
        $display("FAIL load_down[%0d]: count=%h tc=%b wrap=%b want %h/%b/%b",
                 i, count_w, tc_w, wrap_w, exp_cnt[i], (exp_cnt[i] == 4'h0), (i == 4));
      end
    end
    tick();
    total++;
    if (count_w !== 4'hE || wrap_w !== 1'b0) begin
      bad++;
      $display("FAIL load_down_after: count=%h wrap=%b want E/0", count_w, wrap_w);
    end
  endtask

  task automatic test_priority_mode();
    do_reset();
    mode = 2'b10; load = 1'b1; enable = 1'b1; load_value = 4'h9;
    tick();
    total++;
    if (count_w !== 4'hD) begin
      bad++;
      $display("FAIL load_priority: count=%h want D", count_w);
    end
    mode = 2'b00; load = 1'b1; enable = 1'b0; load_value = 4'h5;
    tick();
    total++;
    if (count_w !== 4'h5) begin
      bad++;
      $display("FAIL load5: count=%h want 5", count_w);
    end
    load = 1'b0; mode = 2'b11; enable = 1'b1;
    tick();
    total++;
    if (count_w !== 4'h6) begin
      bad++;
      $display("FAIL mode_switch: count=%h want 6", count_w);
    end
    enable = 1'b0; mode = 2'b00;
    tick();
    total++;
    if (count_w !== 4'h4 || wrap_w !== 1'b0) begin
      bad++;
      $display("FAIL reencode: count=%h wrap=%b want 4/0", count_w, wrap_w);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    mode = 2'b00; load = 1'b1; load_value = 4'hF;
    tick();
    load = 1'b0; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (count_s !== 4'hF || wrap_s !== 1'b0 || tc_s !== 1'b1) begin
        bad++;
        $display("FAIL sat_up[%0d]: count=%h wrap=%b tc=%b want F/0/1", i, count_s, wrap_s, tc_s);
      end
      if (i == 0) begin
        total++;
        if (count_w !== 4'h0 || wrap_w !== 1'b1) begin
          bad++;
          $display("FAIL wrap_ref: count=%h wrap=%b want 0/1", count_w, wrap_w);
        end
      end
    end
    mode = 2'b01; load = 1'b1; load_value = 4'h0; enable = 1'b0;
    tick();
    load = 1'b0; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (count_s !== 4'h0 || wrap_s !== 1'b0 || tc_s !== 1'b1) begin
        bad++;
        $display("FAIL sat_down[%0d]: count=%h wrap=%b tc=%b want 0/0/1", i, count_s, wrap_s, tc_s);
      end
    end
  endtask

  initial begin
    nreset = 1'b0; enable = 1'b0; load = 1'b0; mode = 2'b00; load_value = 4'h0;
    test_reset();
    test_async_reset();
    test_bin_up();
    test_gray_up();
    test_load_down();
    test_priority_mode();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
